// File: rtl/cntr_event_fifo.sv
// cntr_event_fifo: detects threshold-match and drop events on counter updates and queues them in a FWFT FIFO
module cntr_event_fifo #(
  parameter int DEPTH = 4,
  parameter int CW = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CW-1:0]              cnt_in,
  input  logic                       cnt_upd,
  input  logic [CW-1:0]              thr_in,
  input  logic                       thr_load,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [1:0]                 ev_type,
  output logic [CW-1:0]              ev_value,
  output logic [$clog2(DEPTH):0]     ev_level,
  output logic                       ovf,
  input  logic                       ovf_clr,
  output logic [15:0]                drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [CW-1:0] thr, prev_val;
  logic prev_vld;
  logic [CW+1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, rp_n;
  logic match, drop, push, pop, accept, lost;
  logic [LW-1:0] after_pop, level_n;
  logic [CW+1:0] rec, head_n;
  always_comb begin
    match = cnt_upd && cnt_in == thr && (!prev_vld || cnt_in != prev_val);
    drop = cnt_upd && prev_vld && cnt_in < prev_val;
    push = match || drop;
    pop = ev_valid && ev_ready;
    accept = push && (ev_level != LW'(DEPTH) || pop);
    lost = push && !accept;
    rec = {drop, match, cnt_in};
    rp_n = rp + AW'(pop);
    after_pop = ev_level - LW'(pop);
    level_n = after_pop + LW'(accept);
    // a record pushed into a FIFO that is empty after this pop goes straight to the head
    head_n = after_pop == '0 ? rec : mem[rp_n];
  end
  always_ff @(posedge clk)
    if (accept) mem[wp] <= rec;
  always_ff @(posedge clk) begin
    if (!rst) begin
      thr <= '1;
      prev_val <= '0;
      prev_vld <= 1'b0;
      wp <= '0;
      rp <= '0;
      ev_level <= '0;
      ev_valid <= 1'b0;
      ev_type <= '0;
      ev_value <= '0;
      ovf <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (thr_load) thr <= thr_in;
      if (cnt_upd) begin
        prev_val <= cnt_in;
        prev_vld <= 1'b1;
      end
      wp <= wp + AW'(accept);
      rp <= rp_n;
      ev_level <= level_n;
      ev_valid <= level_n != '0;
      if (level_n != '0) {ev_type, ev_value} <= head_n;
      if (ovf_clr) begin
        ovf <= lost;
        drop_cnt <= {15'd0, lost};
      end else if (lost) begin
        ovf <= 1'b1;
        drop_cnt <= drop_cnt + 16'(drop_cnt != 16'hFFFF);
      end
    end
  end
endmodule

// File: tb/tb_cntr_event_fifo.sv
// tb_cntr_event_fifo: directed and random stimulus checked against a queue-based event model
module tb_cntr_event_fifo;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0, cnt_upd = 0, thr_load = 0, ev_ready = 0, ovf_clr = 0;
  logic [31:0] cnt_in = 0, thr_in = 0;
  logic ev_valid, ovf;
  logic [1:0] ev_type;
  logic [31:0] ev_value;
  logic [2:0] ev_level;
  logic [15:0] drop_cnt;
  int checks = 0, passes = 0;
  logic [31:0] m_thr, m_prev;
  bit m_pv, m_ovf;
  int m_dc;
  logic [33:0] q[$];

  cntr_event_fifo #(.DEPTH(DEPTH), .CW(32)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_upd(cnt_upd), .thr_in(thr_in),
    .thr_load(thr_load), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_value(ev_value), .ev_level(ev_level), .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model(input bit r, u, input logic [31:0] c, input bit rdy, tl,
                       input logic [31:0] tv, input bit clr);
    bit mt, dr, pop, full, lost;
    if (!r) begin
      m_thr = '1; m_prev = 0; m_pv = 0; m_ovf = 0; m_dc = 0; q.delete();
      return;
    end
    mt = u && c == m_thr && (!m_pv || c != m_prev);
    dr = u && m_pv && c < m_prev;
    pop = q.size() != 0 && rdy;
    full = q.size() == DEPTH;
    lost = 0;
    if (pop) void'(q.pop_front());
    if (mt || dr) begin
      if (!full || pop) q.push_back({dr, mt, c});
      else lost = 1;
    end
    if (clr) begin
      m_ovf = lost; m_dc = lost ? 1 : 0;
    end else if (lost) begin
      m_ovf = 1; if (m_dc < 65535) m_dc++;
    end
    if (u) begin m_prev = c; m_pv = 1; end
    if (tl) m_thr = tv;
  endtask

  task automatic cyc(input bit r, u, input logic [31:0] c, input bit rdy,
                     input bit tl = 0, input logic [31:0] tv = 0, input bit clr = 0);
    rst = r; cnt_upd = u; cnt_in = c; ev_ready = rdy; thr_load = tl; thr_in = tv; ovf_clr = clr;
    @(posedge clk);
    #1;
    model(r, u, c, rdy, tl, tv, clr);
    chk("ev_valid", ev_valid, q.size() != 0);
    chk("ev_level", ev_level, q.size());
    chk("ovf", ovf, m_ovf);
    chk("drop_cnt", drop_cnt, m_dc);
    if (q.size() != 0) begin
      chk("ev_type", ev_type, q[0][33:32]);
      chk("ev_value", ev_value, q[0][31:0]);
    end
  endtask

  initial begin
    bit r, tl, clr;
    logic [31:0] c;
    cyc(0, 0, 0, 0);
    chk("rst_type", ev_type, 0);
    chk("rst_value", ev_value, 0);
    // threshold 5, count 1..6 with consumer stalled
    cyc(1, 0, 0, 0, 1, 5);
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 1, i, 0);
      if (i == 5) chk("match5_valid", ev_valid, 1);
    end
    chk("match5_level", ev_level, 1);
    chk("match5_rec", {ev_type, ev_value}, {2'b01, 32'd5});
    cyc(1, 0, 0, 1);
    // held at threshold fires once, then a clear to zero drops
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 3);
    for (int i = 0; i < 3; i++) cyc(1, 1, 3, 0);
    cyc(1, 1, 0, 0);
    chk("hold3_level", ev_level, 2);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    // threshold 0: drop to zero is both events; 32-bit wrap drops
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 7, 0);
    cyc(1, 1, 0, 0);
    chk("both_rec", {ev_type, ev_value}, {2'b11, 32'd0});
    cyc(1, 1, 32'hFFFF_FFFF, 1);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 1);
    // overflow: six drops into a stalled four-entry FIFO
    cyc(0, 0, 0, 0);
    cyc(1, 1, 10, 0);
    for (int i = 9; i >= 4; i--) cyc(1, 1, i, 0);
    chk("ovf_level", ev_level, 4);
    chk("ovf_flag", ovf, 1);
    chk("ovf_cnt", drop_cnt, 2);
    cyc(1, 1, 3, 1);
    chk("fullpp_level", ev_level, 4);
    chk("fullpp_cnt", drop_cnt, 2);
    cyc(1, 1, 2, 0, 0, 0, 1);
    chk("clr_drop_ovf", ovf, 1);
    chk("clr_drop_cnt", drop_cnt, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    chk("clr_ovf", ovf, 0);
    chk("clr_cnt", drop_cnt, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1);
    // reset with three queued records
    cyc(1, 1, 3, 0);
    cyc(1, 1, 2, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    chk("pre_rst_level", ev_level, 3);
    cyc(0, 0, 0, 0);
    chk("post_rst_valid", ev_valid, 0);
    chk("post_rst_level", ev_level, 0);
    cyc(1, 1, 32'hFFFF_FFFF, 0);
    chk("rst_thr_rec", {ev_valid, ev_type, ev_value}, {1'b1, 2'b01, 32'hFFFF_FFFF});
    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99) != 0;
      c = $urandom_range(0, 9) == 0 ? 32'hFFFF_FFFF : 32'($urandom_range(0, 7));
      tl = $urandom_range(0, 7) == 0;
      clr = $urandom_range(0, 15) == 0;
      cyc(r, $urandom_range(0, 3) != 0, c, $urandom_range(0, 9) < 4, tl,
          32'($urandom_range(0, 7)), clr);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/cntr_event_fifo.md
Name: cntr_event_fifo

Overview:
- Downstream consumer of the counter datapath.
- Samples the counter output value on every counter update strobe and detects two events:
  - threshold match: the value reaches a programmable threshold;
  - drop: the value is lower than the previous sample, which happens on a clear or a 32-bit wrap.
- Each event is queued as a {type, value} record in a small FIFO and presented to the next stage on a valid/ready interface, with overflow accounting.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, 32, counter value width; must equal the counter datapath width.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  reset; one clock, synchronous, active-low (rst==0 resets on posedge clk).
- cnt_in  in  CW  counter value (unsigned), driven from the counter output register.
- cnt_upd  in  1  high for one cycle when cnt_in holds a newly written counter value.
- thr_in  in  CW  threshold value to load.
- thr_load  in  1  load thr_in into the threshold register.
- ev_valid  out  1  head FIFO record is valid.
- ev_ready  in  1  consumer accepts the head record.
- ev_type  out  2  head record type: 01 match, 10 drop, 11 both.
- ev_value  out  CW  cnt_in captured with the record.
- ev_level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- ovf  out  1  sticky: at least one record was lost.
- ovf_clr  in  1  clears ovf and drop_cnt.
- drop_cnt  out  16  count of lost records, saturating.

Behaviour:
- Reset (rst==0 at posedge), values after reset:
  - threshold register = all ones; prev_val = 0; prev_vld = 0.
  - FIFO empty; ev_valid = 0; ev_type = 0; ev_value = 0; ev_level = 0.
  - ovf = 0; drop_cnt = 0.
  - Reset mid-operation discards all queued records with no drain.
- Threshold:
  - thr_load writes the threshold register at the posedge.
  - Event evaluation in that same cycle uses the old threshold; the new value applies from the next cycle.
- Event evaluation, only in cycles with cnt_upd==1:
  - match = (cnt_in == thr) && (!prev_vld || cnt_in != prev_val). A counter held at the threshold fires match once, not on every repeated update.
  - drop = prev_vld && (cnt_in < prev_val), unsigned compare. The first sample after reset never produces a drop.
  - Then prev_val <= cnt_in and prev_vld <= 1.
  - If match or drop: push record {drop, match} with value cnt_in.
  - cnt_upd==0: no evaluation; prev_val and prev_vld are unchanged.
- FIFO:
  - Registered outputs, first-word-fall-through.
  - A push into an empty FIFO shows ev_valid=1 in the cycle after the cnt_upd cycle (latency 1).
  - Pop happens when ev_valid && ev_ready. The next record, if any, is presented in the following cycle with no bubble.
  - While ev_valid && !ev_ready, ev_type, ev_value and ev_valid hold stable.
  - ev_type and ev_value hold their last value when the FIFO goes empty; they are don't-care for checking while ev_valid==0.
  - ev_level updates at the same posedge as the push or pop; push+pop together leaves it unchanged.
- Full boundary:
  - Push and pop in the same cycle while full: the push is accepted and the level stays at DEPTH.
  - Push while full with no pop: the record is dropped, ovf <= 1, and drop_cnt increments, saturating at 0xFFFF.
- Overflow clear:
  - ovf_clr clears ovf and drop_cnt at the posedge.
  - A drop in the same cycle as ovf_clr wins: ovf = 1 and drop_cnt = 1.
- Pointer wrap: read and write pointers wrap modulo DEPTH; full and empty are distinguished by the occupancy counter.
- All arithmetic is unsigned; no wrap of cnt_in is inferred other than through the drop rule.

Test Plan:
- Reset, then thr_load with thr_in=5; cnt_upd with cnt_in=1..6 -> exactly one record {01,5}, with ev_valid rising the cycle after cnt_in=5; ev_level peaks at 1 while ev_ready=0.
- Threshold=3; cnt_in sequence 3,3,3 on consecutive cnt_upd -> one match record only; then cnt_in=0 -> record {10,0}.
- Threshold=0; cnt_in 7 then 0 -> single record {11,0}. Also cnt_in 0xFFFFFFFF then 0x0 -> drop record on the wrap.
- ev_ready=0, DEPTH=4, produce 6 events -> ev_level=4, ovf=1, drop_cnt=2; the first 4 records drain in order once ready is raised. With a full FIFO, push and ev_ready in the same cycle -> no drop, ev_level stays 4.
- ovf_clr asserted in the same cycle as a dropped push -> ovf=1, drop_cnt=1. ovf_clr alone the next cycle -> ovf=0, drop_cnt=0.
- rst=0 asserted with 3 records queued and ev_valid=1 -> next cycle: ev_valid=0, ev_level=0, and the threshold register reads back as 0xFFFFFFFF via a match at cnt_in=0xFFFFFFFF.
